apu_write_scheduler: RTL
========================

APU_WRITE_SCHEDULER -- requirements
Module: apu_write_scheduler

Interface
REQ-001 SHALL have parameter CLKRATE, default 12_000_000, oscillator frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 9600, serial baud rate of the upstream receiver.
REQ-003 SHALL have parameter LINK_HOLD, default CLKRATE/8, link indicator hold time in osc cycles.
REQ-004 SHALL derive localparam TIMEOUT = 20*CLKRATE/BAUDRATE (25000 cycles at defaults), the inter-byte timeout.
REQ-005 SHALL have port osc, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rx_data, input, 8, received serial byte.
REQ-008 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-009 SHALL have port wr_ready, input, 1, APU register file accepts a write.
REQ-010 SHALL have port wr_valid, output, 1, register write pending.
REQ-011 SHALL have port wr_addr, output, 5, APU register index.
REQ-012 SHALL have port wr_data, output, 8, APU register value.
REQ-013 SHALL have port link, output, 1, link LED drive.
REQ-014 SHALL have port err, output, 1, one-cycle protocol/overflow error pulse.

Function
REQ-015 SHALL parse packets of two bytes: address byte (bit7=1, index=bits[4:0], bits[6:5] ignored) then data byte (any value).
REQ-016 SHALL implement states ADDR and DATA; ADDR on rx_valid with bit7=1 latches index and moves to DATA.
REQ-017 SHALL, in ADDR, discard a byte with bit7=0 and pulse err for one cycle.
REQ-018 SHALL, in DATA, on rx_valid push {index,byte} into the write FIFO and return to ADDR.
REQ-019 SHALL, in DATA, count osc cycles since the address byte; at TIMEOUT return to ADDR and pulse err.
REQ-020 SHALL, when timeout expiry and rx_valid coincide, process the byte and ignore the timeout.
REQ-021 SHALL buffer writes in a 2-entry FIFO; wr_valid = FIFO not empty; wr_addr/wr_data = head entry.
REQ-022 SHALL hold wr_addr/wr_data stable while wr_valid=1 and wr_ready=0.
REQ-023 SHALL pop the head on a rising edge where wr_valid=1 and wr_ready=1.
REQ-024 SHALL assert wr_valid the cycle after the data-byte rx_valid when the FIFO was empty (latency 1).
REQ-025 SHALL, on push while full without a simultaneous pop, drop the new entry and pulse err; with a simultaneous pop, accept it.
REQ-026 SHALL preserve write order (FIFO order); pointers wrap modulo 2.
REQ-027 SHALL drive link=1 for LINK_HOLD cycles after each popped write, retriggering on each pop; otherwise 0.
REQ-028 SHALL ignore rx_data when rx_valid=0.

Reset
REQ-029 SHALL on rst_n=0 asynchronously force state ADDR, FIFO empty, timeout and link counters zero.
REQ-030 SHALL reset outputs: wr_valid=0, wr_addr=0, wr_data=0, link=0, err=0.
REQ-031 SHALL, on reset mid-packet or with FIFO occupied, discard all partial and pending writes.

Configuration
REQ-032 SHALL support macro ADDR_CHECK_EN.
REQ-033 SHALL, with ADDR_CHECK_EN defined, treat address bytes with index >= 24 as invalid: discard, pulse err, stay in ADDR.
REQ-034 SHALL, without ADDR_CHECK_EN, accept all 32 indices.

Verification
REQ-035 SHALL cover: bytes 0x83,0x5A with wr_ready=1 -> one wr_valid cycle, wr_addr=3, wr_data=0x5A, link high LINK_HOLD cycles.
REQ-036 SHALL cover: 0x81,0x11,0x82,0x22,0x84,0x33 with wr_ready=0 -> two entries held (addr 1, 2), third dropped with err pulse; after wr_ready=1 writes 1/0x11 then 2/0x22.
REQ-037 SHALL cover: 0x85 then no byte for 25000 cycles -> err pulse, state ADDR; next 0x42 -> err pulse, no write.
REQ-038 SHALL cover: 0x9F,0x01 -> with ADDR_CHECK_EN err and no write; without it write addr 31, data 0x01.
REQ-039 SHALL cover: rst_n low after 0x86 and with one FIFO entry pending -> wr_valid=0 immediately; 0x07 after reset gives err, no write.
REQ-040 SHALL cover: data byte arriving on exact timeout cycle -> write issued, no err.

Source files
------------

// File: rtl/apu_write_scheduler.sv
// Serial byte-pair parser feeding APU register writes through a 2-entry FIFO.
// Define ADDR_CHECK_EN to reject address bytes whose index is 24 or above.
module apu_write_scheduler #(
   parameter int CLKRATE   = 12_000_000,
   parameter int BAUDRATE  = 9600,
   parameter int LINK_HOLD = CLKRATE / 8
) (
   input  logic       osc,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       wr_ready,
   output logic       wr_valid,
   output logic [4:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       link,
   output logic       err
);

   localparam int TIMEOUT = 20 * CLKRATE / BAUDRATE;
   localparam int TW      = $clog2(TIMEOUT + 1);
   localparam int LW      = $clog2(LINK_HOLD + 1);

   localparam logic [0:0] ADDR = 1'b0;
   localparam logic [0:0] DATA = 1'b1;

   logic [0:0]    state;
   logic [4:0]    idx;
   logic [TW-1:0] tcnt;

   logic          addr_ok;
   logic          in_data;
   logic          tmo;
   logic          push;
   logic          perr;

   logic [12:0]   mem [2];
   logic          wptr;
   logic          rptr;
   logic [1:0]    cnt;
   logic          full;
   logic          pop;
   logic          push_ok;

   logic [LW-1:0] link_cnt;

   // ---------------- packet parser ----------------

`ifdef ADDR_CHECK_EN
   assign addr_ok = rx_valid && rx_data[7] && (rx_data[4:0] < 5'd24);
`else
   assign addr_ok = rx_valid && rx_data[7];
`endif

   assign in_data = (state == DATA);
   assign push    = in_data && rx_valid;
   assign perr    = !in_data && rx_valid && !addr_ok;

   // A data byte on the expiry cycle wins over the timeout.
   assign tmo = in_data && !rx_valid &&
                (tcnt == TW'(TIMEOUT - 1));

   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         state <= ADDR;
         idx   <= '0;
         tcnt  <= '0;
      end else begin
         case (state)
            ADDR: begin
               if (addr_ok) begin
                  state <= DATA;
                  idx   <= rx_data[4:0];
                  tcnt  <= '0;
               end
            end
            DATA: begin
               if (rx_valid || tmo) begin
                  state <= ADDR;
                  tcnt  <= '0;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: begin
               state <= ADDR;
               tcnt  <= '0;
            end
         endcase
      end
   end

   // ---------------- write FIFO ----------------

   assign wr_valid = (cnt != 2'd0);
   assign full     = (cnt == 2'd2);
   assign pop      = wr_valid && wr_ready;
   assign push_ok  = push && (!full || pop);

   assign {wr_addr, wr_data} = mem[rptr];

   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wptr   <= 1'b0;
         rptr   <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push_ok) begin
            mem[wptr] <= {idx, rx_data};
            wptr      <= ~wptr;
         end
         if (pop) begin
            rptr <= ~rptr;
         end
         cnt <= cnt + {1'b0, push_ok} - {1'b0, pop};
      end
   end

   // ---------------- status outputs ----------------

   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else begin
         err <= perr || tmo || (push && !push_ok);
      end
   end

   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         link_cnt <= '0;
      end else if (pop) begin
         link_cnt <= LW'(LINK_HOLD);
      end else if (link_cnt != '0) begin
         link_cnt <= link_cnt - LW'(1);
      end
   end

   assign link = (link_cnt != '0);

endmodule
